lc3_wait_memory: RTL and testbench
==================================

LC3_WAIT_MEMORY -- requirements
Module: lc3_wait_memory

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits.
REQ-002 Parameter ADDR_W, default 16: address width in bits.
REQ-003 Parameter DEPTH, default 65536: number of implemented words; legal range 1..2^ADDR_W.
REQ-004 Parameter RD_LAT, default 0: extra wait cycles per read; legal range 0..15.
REQ-005 Parameter WR_LAT, default 0: extra wait cycles per write; legal range 0..15.
REQ-006 Parameter INIT_FILE, default "": hex image loaded into the array at time zero when non-empty.
REQ-007 Port clock, input, 1: single clock; all state changes on the rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port addr, input, ADDR_W: word address of the request.
REQ-010 Port din, input, DATA_W: write data.
REQ-011 Port rd, input, 1: read request.
REQ-012 Port wr, input, 1: write request.
REQ-013 Port dout, output, DATA_W: registered read data.
REQ-014 Port complete, output, 1: one-cycle access-done strobe.
REQ-015 Port err, output, 1: out-of-range strobe, valid only while complete is high.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-017 In IDLE, rd or wr high at a rising edge SHALL accept a request and latch addr, din and the operation.
REQ-018 When rd and wr are both high, the request SHALL be treated as a read, with no write performed.
REQ-019 On accept, the block SHALL go to DONE if the selected latency is 0, else to WAIT with the counter loaded to latency-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the block SHALL move to DONE on the edge where the counter equals 0.
REQ-021 Array access SHALL occur on the edge entering DONE: a read loads dout from the array; a write stores the latched din.
REQ-022 complete SHALL be high for exactly the one cycle spent in DONE, i.e. the cycle after edge accept+LAT.
REQ-023 From DONE, the block SHALL return to IDLE unconditionally, ignoring rd/wr during DONE; the requester drops its request while complete is high.
REQ-024 rd/wr/addr/din changes during WAIT or DONE SHALL have no effect; latched values are used.
REQ-025 dout SHALL hold its value until the next completed read; writes SHALL NOT change dout.
REQ-026 An address >= DEPTH SHALL complete normally with err=1; a read returns all-zeros on dout; a write leaves the array unchanged.
REQ-027 Maximum throughput SHALL be one access per LAT+2 cycles.

Reset
REQ-028 reset high at an edge SHALL force IDLE, counter=0, complete=0, err=0 and dout=0, overriding any request in the same cycle.
REQ-029 Reset during WAIT SHALL abort the access; a write not yet at its DONE edge SHALL NOT modify the array.
REQ-030 Array contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package lc3_mem_pkg SHALL hold the state enumeration, default DATA_W/ADDR_W constants and the maximum latency constant 15.
REQ-032 The wait counter SHALL be a sub-module lc3_wait_counter with a 4-bit loadable down-counter and a zero flag.
REQ-033 The array SHALL be a single inferred synchronous RAM with no reset on its storage.

Verification
REQ-034 RD_LAT=0 test: preload ram[16'h3000]=16'h1234 and pulse rd with addr=16'h3000 -> complete high in the cycle after the accept edge with dout=16'h1234, err=0.
REQ-035 WR_LAT=3, RD_LAT=2 test: write 16'hBEEF to 16'h0010, then read 16'h0010 -> write complete 4 cycles after accept; read complete 3 cycles after accept with dout=16'hBEEF.
REQ-036 Simultaneous request test: rd=wr=1 at addr 16'h0020 (contents 16'h0055) with din=16'hFFFF -> dout=16'h0055 and location unchanged.
REQ-037 DEPTH=256 test: read addr 16'h0100 -> complete=1, err=1, dout=16'h0000; write to 16'h0100 leaves ram[16'h0000] unchanged.
REQ-038 WR_LAT=5 reset test: reset asserted 2 cycles after a write accept -> no complete, target word keeps its old value, dout=0, FSM in IDLE.
REQ-039 Held-request test: rd held high through complete with RD_LAT=1 -> exactly one read per 3 cycles, never two complete strobes on consecutive cycles.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg
//   Shared definitions for the LC-3 wait-state memory: FSM state encoding,
//   default data/address widths, the latency ceiling and the wait-counter
//   width.
package lc3_mem_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 16;
  localparam int MAX_LAT        = 15;
  localparam int CNT_W          = 4;   // wide enough for MAX_LAT-1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_wait_counter.sv
// lc3_wait_counter
//   Loadable 4-bit down-counter that paces the WAIT state. It saturates at
//   zero, and zero reports when the count has run out.
//   Ports:
//     clock      - rising-edge clock
//     reset      - synchronous active-high clear
//     load       - load load_value (takes priority over dec)
//     load_value - start value (latency - 1)
//     dec        - decrement by one when non-zero
//     zero       - count == 0
module lc3_wait_counter
  import lc3_mem_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lc3_wait_memory.sv
// lc3_wait_memory
//   Single-port word memory with a configurable number of wait cycles per
//   read and per write. A request is latched in IDLE, optionally waits in
//   WAIT, and the array is accessed on the edge entering DONE, where a
//   one-cycle complete strobe is raised. Out-of-range addresses complete
//   normally with err set; reads return zero and writes are dropped.
//   Ports:
//     clock    - rising-edge clock
//     reset    - synchronous active-high reset (array contents survive)
//     addr     - word address of the request
//     din      - write data
//     rd, wr   - read / write request (both high is a read)
//     dout     - registered read data, held until the next completed read
//     complete - one-cycle access-done strobe
//     err      - out-of-range flag, meaningful only while complete is high
module lc3_wait_memory
  import lc3_mem_pkg::*;
#(
  parameter int    DATA_W    = DEFAULT_DATA_W,
  parameter int    ADDR_W    = DEFAULT_ADDR_W,
  parameter int    DEPTH     = 65536,
  parameter int    RD_LAT    = 0,
  parameter int    WR_LAT    = 0,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] dout,
  output logic              complete,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] RD_CNT = (RD_LAT == 0) ? '0 : CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = (WR_LAT == 0) ? '0 : CNT_W'(WR_LAT - 1);

  state_t            state;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_din;
  logic              cur_lat_zero;
  logic              in_range;
  logic              accept;
  logic              cnt_zero;
  logic              go_done;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // In IDLE the request is taken straight from the ports so a zero-latency
  // access can hit the array on its accept edge; afterwards only the
  // latched copy is used, making port activity during WAIT/DONE harmless.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cur_write = op_write_q;
    cur_addr  = addr_q;
    cur_din   = din_q;
    if (state == IDLE) begin
      cur_write = wr && !rd;
      cur_addr  = addr;
      cur_din   = din;
    end
  end

  assign cur_lat_zero = cur_write ? (WR_LAT == 0) : (RD_LAT == 0);
  assign in_range     = {1'b0, cur_addr} < DEPTH_LIMIT;
  assign idx          = cur_addr[IDX_W-1:0];
  assign accept       = (state == IDLE) && (rd || wr);
  assign go_done      = !reset &&
                        ((accept && cur_lat_zero) || ((state == WAIT) && cnt_zero));

  lc3_wait_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept && !cur_lat_zero),
    .load_value (cur_write ? WR_CNT : RD_CNT),
    .dec        (state == WAIT),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      complete   <= 1'b0;
      err        <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      complete <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_write_q <= cur_write;
            addr_q     <= addr;
            din_q      <= din;
            state      <= cur_lat_zero ? DONE : WAIT;
          end
        end
        WAIT:    if (cnt_zero) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_done) begin
        complete <= 1'b1;
        err      <= !in_range;
      end
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM and
  // keeps its contents across reset; only control state is cleared.
  always_ff @(posedge clock) begin
    if (go_done && cur_write && in_range) begin
      mem[idx] <= cur_din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= '0;
    end else if (go_done && !cur_write) begin
      dout <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_lc3_wait_memory.sv
// Bench for lc3_wait_memory. Four instances cover different parameter
// sets: u0 zero latency, u1 RD_LAT=2/WR_LAT=3, u2 DEPTH=256, u3
// RD_LAT=1/WR_LAT=5 for reset abort and held-request pacing.
module tb_lc3_wait_memory;

  localparam int N = 4;
  localparam int RDL [N] = '{0, 2, 0, 1};
  localparam int WRL [N] = '{0, 3, 0, 5};

  logic              clock = 1'b0;
  logic [N-1:0]      reset;
  logic [N-1:0]      rd;
  logic [N-1:0]      wr;
  logic [15:0]       addr [N];
  logic [15:0]       din  [N];
  wire  [15:0]       dout [N];
  wire  [N-1:0]      complete;
  wire  [N-1:0]      err;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lc3_wait_memory #(.RD_LAT(0), .WR_LAT(0)) u0 (
    .clock(clock), .reset(reset[0]), .addr(addr[0]), .din(din[0]), .rd(rd[0]),
    .wr(wr[0]), .dout(dout[0]), .complete(complete[0]), .err(err[0]));
  lc3_wait_memory #(.RD_LAT(2), .WR_LAT(3)) u1 (
    .clock(clock), .reset(reset[1]), .addr(addr[1]), .din(din[1]), .rd(rd[1]),
    .wr(wr[1]), .dout(dout[1]), .complete(complete[1]), .err(err[1]));
  lc3_wait_memory #(.DEPTH(256)) u2 (
    .clock(clock), .reset(reset[2]), .addr(addr[2]), .din(din[2]), .rd(rd[2]),
    .wr(wr[2]), .dout(dout[2]), .complete(complete[2]), .err(err[2]));
  lc3_wait_memory #(.RD_LAT(1), .WR_LAT(5)) u3 (
    .clock(clock), .reset(reset[3]), .addr(addr[3]), .din(din[3]), .rd(rd[3]),
    .wr(wr[3]), .dout(dout[3]), .complete(complete[3]), .err(err[3]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One complete transaction: request presented for a single accept edge,
  // then ports scrambled so any use of live inputs shows up. lat counts the
  // edges between the accept edge and the edge entering DONE (-1 = timeout).
  task automatic access(input int i, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] q, output logic e, output int lat);
    @(negedge clock);
    check($sformatf("idle_cpl_low_u%0d", i), complete[i], 1'b0);
    rd[i] = r; wr[i] = w; addr[i] = a; din[i] = d;
    @(posedge clock);
    #1;
    rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = ~a; din[i] = ~d;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (complete[i] === 1'b1) begin
        lat = k;
        break;
      end
    end
    q = dout[i];
    e = err[i];
  endtask

  typedef struct {
    int          inst;
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_q;
    logic        exp_e;
  } vec_t;

  vec_t        vecs [$];
  logic [15:0] model [int];
  logic [15:0] q;
  logic        e;
  int          lat;
  int          seen;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = '1; rd = '0; wr = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0;
      din[i]  = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_dout_u%0d", i), dout[i], 16'h0000);
      check($sformatf("rst_cpl_u%0d", i), complete[i], 1'b0);
      check($sformatf("rst_err_u%0d", i), err[i], 1'b0);
    end
    reset = '0;

    // Zero-latency vectors, including the rd+wr collision and DEPTH edges.
    vecs.push_back('{0, 1'b0, 1'b1, 16'h3000, 16'h1234, 16'h0000, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 16'h0020, 16'h0055, 16'h1234, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b1, 16'h0020, 16'hFFFF, 16'h0055, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0055, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 16'hFFFF, 16'hABCD, 16'h0055, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hABCD, 1'b0});
    vecs.push_back('{2, 1'b0, 1'b1, 16'h0000, 16'hA5A5, 16'h0000, 1'b0});
    vecs.push_back('{2, 1'b0, 1'b1, 16'h00FF, 16'h1111, 16'h0000, 1'b0});
    vecs.push_back('{2, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h1111, 1'b0});
    vecs.push_back('{2, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{2, 1'b0, 1'b1, 16'h0100, 16'h5A5A, 16'h0000, 1'b1});
    vecs.push_back('{2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0});
    foreach (vecs[v]) begin
      access(vecs[v].inst, vecs[v].r, vecs[v].w, vecs[v].a, vecs[v].d, q, e, lat);
      check($sformatf("vec%0d_dout", v), q, vecs[v].exp_q);
      check($sformatf("vec%0d_err", v), e, vecs[v].exp_e);
      check($sformatf("vec%0d_lat", v), lat, 0);
    end

    // Multi-cycle write then read on u1.
    access(1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, q, e, lat);
    check("lat_wr_u1", lat, WRL[1]);
    check("lat_wr_err", e, 1'b0);
    access(1, 1'b1, 1'b0, 16'h0010, 16'h0000, q, e, lat);
    check("lat_rd_u1", lat, RDL[1]);
    check("lat_rd_dout", q, 16'hBEEF);

    // Random traffic on u1 against an associative-array memory model.
    for (int k = 0; k < 16; k++) begin
      model[16'h4000 + k] = 16'($urandom);
      access(1, 1'b0, 1'b1, 16'(16'h4000 + k), model[16'h4000 + k], q, e, lat);
    end
    check("rnd_init_dout", q, 16'hBEEF);
    begin
      logic [15:0] exp_q;
      exp_q = 16'hBEEF;
      for (int n = 0; n < 40; n++) begin
        int          op;
        logic [15:0] a;
        logic [15:0] d;
        op = int'($urandom_range(0, 2));
        a  = 16'(16'h4000 + $urandom_range(0, 15));
        d  = 16'($urandom);
        access(1, op != 1, op != 0, a, d, q, e, lat);
        if (op == 1) begin
          model[a] = d;
          check($sformatf("rnd%0d_lat_wr", n), lat, WRL[1]);
        end else begin
          exp_q = model[a];
          check($sformatf("rnd%0d_lat_rd", n), lat, RDL[1]);
        end
        check($sformatf("rnd%0d_dout", n), q, exp_q);
        check($sformatf("rnd%0d_err", n), e, 1'b0);
      end
    end

    // Reset two edges into a long write aborts it on u3.
    access(3, 1'b0, 1'b1, 16'h0040, 16'h1111, q, e, lat);
    check("u3_wr_lat", lat, WRL[3]);
    access(3, 1'b1, 1'b0, 16'h0040, 16'h0000, q, e, lat);
    check("u3_rd_dout", q, 16'h1111);
    @(negedge clock);
    rd[3] = 1'b0; wr[3] = 1'b1; addr[3] = 16'h0040; din[3] = 16'h2222;
    @(posedge clock);
    #1;
    wr[3] = 1'b0;
    @(negedge clock);
    check("abort_cpl_a", complete[3], 1'b0);
    @(negedge clock);
    check("abort_cpl_b", complete[3], 1'b0);
    reset[3] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort_rst_cpl", complete[3], 1'b0);
    check("abort_rst_dout", dout[3], 16'h0000);
    check("abort_rst_err", err[3], 1'b0);
    reset[3] = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (complete[3] === 1'b1) seen++;
    end
    check("abort_no_cpl", seen, 0);
    access(3, 1'b1, 1'b0, 16'h0040, 16'h0000, q, e, lat);
    check("abort_word_kept", q, 16'h1111);
    check("abort_idle_lat", lat, RDL[3]);

    // rd held high: one access every RD_LAT+2 cycles, strobes never adjacent.
    @(negedge clock);
    rd[3] = 1'b1; addr[3] = 16'h0040;
    @(posedge clock);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      check($sformatf("hold_cpl_%0d", k), complete[3], ((k % 3) == 1));
      if ((k % 3) == 1) check($sformatf("hold_dout_%0d", k), dout[3], 16'h1111);
    end
    rd[3] = 1'b0;
    repeat (4) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
